// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - shared AXI types, FSM states and beat address helper
package axi_sram_slave_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  strobe_t;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    localparam int AXI_MAX_BEATS = 16;

    typedef enum logic [2:0] {
        IDLE,
        RWAIT,
        RDATA,
        WDATA,
        WRESP
    } state_t;

    // Wrap keeps the upper bits of base and wraps the low bits inside a
    // (len+1)<<size byte window.
    function automatic addr_t beat_addr(input addr_t base, input logic [4:0] beat,
                                        input logic [2:0] size, input logic [3:0] len,
                                        input logic wrap, input logic fixed);
        addr_t incr;
        addr_t mask;
        incr = base + (addr_t'(beat) << size);
        mask = ((addr_t'(len) + 32'd1) << size) - 32'd1;
        if (fixed)
            beat_addr = base;
        else if (wrap)
            beat_addr = (base & ~mask) | (incr & mask);
        else
            beat_addr = incr;
    endfunction

endpackage

// File: rtl/axi_sram_slave_sram_byteen.sv
// rtl/axi_sram_slave_sram_byteen.sv - word array, byte-enabled sync write, combinational read
module sram_byteen
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  strobe_t              be,
    input  logic [ADDR_BITS-1:0] addr,
    input  word_t                wdata,
    output word_t                rdata
);

    word_t mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-outstanding AXI3 SRAM responder; AXI_SLAVE_WRAP_EN enables WRAP bursts
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int RLAT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [3:0] LAT_INIT = (RLAT > 1) ? 4'(RLAT - 2) : 4'd0;

    state_t     state, state_n;
    logic       prio_read;
    logic [3:0] id_q;
    logic [3:0] len_q;
    logic [2:0] size_q;
    axi_burst_t burst_q;
    addr_t      base_q;
    logic [4:0] beat_q;
    logic [3:0] lat_q;
    logic       werr_q;

    logic  ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic  is_wrap, wrap_bad, size_bad, bad, beat_last, mem_we;
    addr_t cur_addr;
    word_t mem_rdata;

`ifdef AXI_SLAVE_WRAP_EN
    assign is_wrap  = (burst_q == WRAP);
    // Wrap lengths must be 2, 4, 8 or 16 beats.
    assign wrap_bad = is_wrap & ((len_q == 4'd0) | ((len_q & (len_q + 4'd1)) != 4'd0));
`else
    assign is_wrap  = 1'b0;
    assign wrap_bad = 1'b0;
`endif

    assign size_bad  = (size_q > 3'd2);
    assign bad       = size_bad | wrap_bad;
    assign cur_addr  = beat_addr(base_q, beat_q, size_q, len_q, is_wrap, burst_q == FIXED);
    assign beat_last = (beat_q == {1'b0, len_q});

    assign arready = !reset && state == IDLE && (!awvalid || prio_read);
    assign awready = !reset && state == IDLE && (!arvalid || !prio_read);
    assign rvalid  = !reset && state == RDATA;
    assign wready  = !reset && state == WDATA;
    assign bvalid  = !reset && state == WRESP;

    assign ar_hs = arvalid & arready;
    assign aw_hs = awvalid & awready;
    assign r_hs  = rvalid & rready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;

    assign rid   = rvalid ? id_q : 4'd0;
    assign rdata = (rvalid && !bad) ? mem_rdata : 32'd0;
    assign rresp = (rvalid && bad) ? SLVERR : OKAY;
    assign rlast = rvalid & beat_last;
    assign bid   = bvalid ? id_q : 4'd0;
    assign bresp = (bvalid && (werr_q || bad)) ? SLVERR : OKAY;

    // Overrun beats past len still handshake but never reach the array.
    assign mem_we = w_hs && (beat_q <= {1'b0, len_q}) && !bad;

    sram_byteen #(.ADDR_BITS(ADDR_BITS)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (wstrb),
        .addr  (cur_addr[ADDR_BITS+1:2]),
        .wdata (wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (ar_hs)
                    state_n = (RLAT == 1) ? RDATA : RWAIT;
                else if (aw_hs)
                    state_n = WDATA;
            end
            RWAIT:   if (lat_q == 4'd0) state_n = RDATA;
            RDATA:   if (r_hs && beat_last) state_n = IDLE;
            WDATA:   if (w_hs && wlast) state_n = WRESP;
            WRESP:   if (b_hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prio_read <= 1'b1;
            beat_q    <= 5'd0;
            lat_q     <= 4'd0;
            werr_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (ar_hs || aw_hs) begin
                prio_read <= !prio_read;
                beat_q    <= 5'd0;
                werr_q    <= 1'b0;
                lat_q     <= LAT_INIT;
                id_q      <= ar_hs ? arid    : awid;
                base_q    <= ar_hs ? araddr  : awaddr;
                len_q     <= ar_hs ? arlen   : awlen;
                size_q    <= ar_hs ? arsize  : awsize;
                burst_q   <= axi_burst_t'(ar_hs ? arburst : awburst);
            end
            if (state == RWAIT && lat_q != 4'd0)
                lat_q <= lat_q - 4'd1;
            if (r_hs && !beat_last)
                beat_q <= beat_q + 5'd1;
            if (w_hs) begin
                if (beat_q != 5'd31)
                    beat_q <= beat_q + 5'd1;
                if (wlast && !beat_last)
                    werr_q <= 1'b1;
            end
        end
    end

    wire unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                       cur_addr[31:ADDR_BITS+2], cur_addr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed-vector bench for axi_sram_slave
module tb_axi_sram_slave;

    localparam int RLAT = 3;

    logic        clk, reset;
    logic [3:0]  arid, awid, wid, rid, bid, arlen, awlen, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_n, rd_lat;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    axi_sram_slave #(.ADDR_BITS(16), .RLAT(RLAT)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
        araddr = a; arlen = len; arsize = size; arburst = burst; arid = id;
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
        awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        logic ok = 1'b0;
        set_ar(a, len, size, burst, id);
        arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1 ok = arready;
            cyc();
        end
        arvalid = 1'b0;
        chk("ar_handshake", 32'(ok), 32'd1);
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id);
        logic ok = 1'b0;
        set_aw(a, len, size, burst, id);
        awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1 ok = awready;
            cyc();
        end
        awvalid = 1'b0;
        chk("aw_handshake", 32'(ok), 32'd1);
    endtask

    task automatic do_w(input int n);
        for (int b = 0; b < n; b++) begin
            logic ok = 1'b0;
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == n - 1); wvalid = 1'b1;
            for (int i = 0; i < 50 && !ok; i++) begin
                #1 ok = wready;
                cyc();
            end
            if (!ok) chk("w_handshake", 32'(ok), 32'd1);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b();
        logic ok = 1'b0;
        bready = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (bvalid) begin
                ok = 1'b1; b_resp = bresp; b_id = bid;
            end
            cyc();
        end
        bready = 1'b0;
        chk("b_handshake", 32'(ok), 32'd1);
    endtask

    task automatic rd_phase(input logic toggle);
        logic        done = 1'b0;
        logic        stalled = 1'b0;
        logic [31:0] stall_val = 32'd0;
        rd_n = 0; rd_lat = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            rready = toggle ? (c % 2 == 1) : 1'b1;
            #1;
            if (rvalid && rd_lat == 0) rd_lat = c + 1;
            if (rvalid && stalled) begin
                chk("stable_rdata", rdata, stall_val);
                stalled = 1'b0;
            end
            if (rvalid && rready) begin
                if (rd_n < 16) begin
                    rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp;
                    rd_last[rd_n] = rlast; rd_id[rd_n] = rid;
                end
                rd_n++;
                if (rlast) done = 1'b1;
            end else if (rvalid) begin
                stalled = 1'b1; stall_val = rdata;
            end
            cyc();
        end
        rready = 1'b0;
        if (!done) chk("rd_complete", 32'(done), 32'd1);
    endtask

    task automatic contest(input logic [31:0] a, output logic ar_rdy, output logic aw_rdy);
        set_ar(a, 4'd0, 3'd2, 2'b01, 4'd1);
        set_aw(32'h500, 4'd0, 3'd2, 2'b01, 4'd7);
        arvalid = 1'b1; awvalid = 1'b1;
        #1 ar_rdy = arready; aw_rdy = awready;
        cyc();
        arvalid = 1'b0; awvalid = 1'b0;
    endtask

    logic ar_rdy, aw_rdy;
    logic [31:0] wrap_exp [4];
    int hs;

    initial begin
        reset = 1'b1;
        {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid} = '0;
        {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
        {wid, wdata, wstrb, wlast, wvalid, rready, bready} = '0;

        // Outputs stay low under reset even with requests pending
        cyc(); cyc();
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        arvalid = 1'b0; awvalid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        #1;
        chk("idle_arready", 32'(arready), 32'd1);
        chk("idle_awready", 32'(awready), 32'd1);
        cyc();

        // Contested address channels: read wins first, then write
        contest(32'h100, ar_rdy, aw_rdy);
        chk("contest1_ar", 32'(ar_rdy), 32'd1);
        chk("contest1_aw", 32'(aw_rdy), 32'd0);
        rd_phase(1'b0);
        contest(32'h100, ar_rdy, aw_rdy);
        chk("contest2_ar", 32'(ar_rdy), 32'd0);
        chk("contest2_aw", 32'(aw_rdy), 32'd1);
        wd[0] = 32'hA5A5_0001; ws[0] = 4'hF;
        do_w(1); do_b();
        chk("contest2_bresp", 32'(b_resp), 32'd0);
        chk("contest2_bid",   32'(b_id),   32'd7);
        do_ar(32'h500, 4'd0, 3'd2, 2'b01, 4'd2);
        rd_phase(1'b0);
        chk("contest2_rdata", rd_data[0], 32'hA5A5_0001);

        // Single write then read
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_aw(32'h100, 4'd0, 3'd2, 2'b01, 4'd3); do_w(1); do_b();
        chk("single_bresp", 32'(b_resp), 32'd0);
        chk("single_bid",   32'(b_id),   32'd3);
        do_ar(32'h100, 4'd0, 3'd2, 2'b01, 4'd5);
        rd_phase(1'b0);
        chk("single_rdata", rd_data[0], 32'hDEAD_BEEF);
        chk("single_rlast", 32'(rd_last[0]), 32'd1);
        chk("single_rresp", 32'(rd_resp[0]), 32'd0);
        chk("single_rid",   32'(rd_id[0]),   32'd5);
        chk("single_lat",   32'(rd_lat),     32'(RLAT));

        // INCR burst, read back with rready toggling
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_aw(32'h200, 4'd3, 3'd2, 2'b01, 4'd4); do_w(4); do_b();
        chk("incr_bresp", 32'(b_resp), 32'd0);
        do_ar(32'h200, 4'd3, 3'd2, 2'b01, 4'd6);
        rd_phase(1'b1);
        chk("incr_nbeats", 32'(rd_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_rdata%0d", i), rd_data[i], 32'(i + 1));
            chk($sformatf("incr_rlast%0d", i), 32'(rd_last[i]), 32'(i == 3));
        end

        // Byte strobes
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        do_aw(32'h300, 4'd0, 3'd2, 2'b01, 4'd1); do_w(1); do_b();
        wd[0] = 32'h0000_AA00; ws[0] = 4'h2;
        do_aw(32'h300, 4'd0, 3'd2, 2'b01, 4'd1); do_w(1); do_b();
        do_ar(32'h300, 4'd0, 3'd2, 2'b01, 4'd1);
        rd_phase(1'b0);
        chk("strb_rdata", rd_data[0], 32'h1122_AA44);

        // Oversized read
        do_ar(32'h100, 4'd0, 3'd3, 2'b01, 4'd1);
        rd_phase(1'b0);
        chk("size3_rresp", 32'(rd_resp[0]), 32'd2);
        chk("size3_rdata", rd_data[0], 32'd0);

        // Early wlast: two beats of a four-beat burst
        wd[0] = 32'h61; wd[1] = 32'h62; ws[0] = 4'hF; ws[1] = 4'hF;
        do_aw(32'h600, 4'd3, 3'd2, 2'b01, 4'd9); do_w(2); do_b();
        chk("early_bresp", 32'(b_resp), 32'd2);
        chk("early_bid",   32'(b_id),   32'd9);
        do_ar(32'h600, 4'd1, 3'd2, 2'b01, 4'd1);
        rd_phase(1'b0);
        chk("early_rdata0", rd_data[0], 32'h61);
        chk("early_rdata1", rd_data[1], 32'h62);

        // WRAP read over words holding their own byte address
        for (int i = 0; i < 6; i++) begin wd[i] = 32'h400 + 32'(4 * i); ws[i] = 4'hF; end
        do_aw(32'h400, 4'd5, 3'd2, 2'b01, 4'd1); do_w(6); do_b();
`ifdef AXI_SLAVE_WRAP_EN
        wrap_exp = '{32'h408, 32'h40C, 32'h400, 32'h404};
`else
        wrap_exp = '{32'h408, 32'h40C, 32'h410, 32'h414};
`endif
        do_ar(32'h408, 4'd3, 3'd2, 2'b10, 4'd1);
        rd_phase(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_rdata%0d", i), rd_data[i], wrap_exp[i]);
            chk($sformatf("wrap_rresp%0d", i), 32'(rd_resp[i]), 32'd0);
        end

        // Reset while beat 2 of a read is presented
        do_ar(32'h200, 4'd3, 3'd2, 2'b01, 4'd1);
        hs = 0;
        for (int c = 0; c < 50 && hs < 2; c++) begin
            rready = 1'b1;
            #1;
            if (rvalid && rready) begin
                chk($sformatf("rst_rd_beat%0d", hs), rdata, 32'(hs + 1));
                hs++;
            end
            cyc();
        end
        chk("rst_rd_beats", 32'(hs), 32'd2);
        reset = 1'b1; rready = 1'b0;
        cyc();
        #1;
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rdata",  rdata,       32'd0);
        reset = 1'b0;
        cyc();
        do_ar(32'h204, 4'd0, 3'd2, 2'b01, 4'd2);
        rd_phase(1'b0);
        chk("postrst_rdata", rd_data[0], 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder backing a word-addressed SRAM; the other end of the CPU-top AXI master port bundle.
- Used as the memory model in CPU simulation and bring-up. Handles one outstanding transaction at a time and supports INCR/FIXED bursts of up to 16 beats, 32-bit data.

Parameters:
ADDR_BITS, 16, word-index width; capacity is 2**ADDR_BITS 32-bit words, and higher address bits alias.
RLAT, 1, cycles from AR handshake to first rvalid (1..15).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
arid/araddr/arlen/arsize/arburst  in  4/32/4/3/2  read address channel
arlock/arcache/arprot  in  2/4/3  ignored
arvalid  in  1; arready  out  1
rid  out  4; rdata  out  32; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1
awid/awaddr/awlen/awsize/awburst  in  4/32/4/3/2  write address channel
awlock/awcache/awprot  in  2/4/3  ignored
awvalid  in  1; awready  out  1
wid  in  4 (ignored); wdata  in  32; wstrb  in  4; wlast  in  1; wvalid  in  1; wready  out  1
bid  out  4; bresp  out  2; bvalid  out  1; bready  in  1

Behaviour:
- Reset: all outputs 0 while reset is high. State enters IDLE, beat counter 0, prio_read=1.
- States: IDLE, RWAIT, RDATA, WDATA, WRESP.
- IDLE handshake:
  - arready = !reset & (!awvalid | prio_read).
  - awready = !reset & (!arvalid | !prio_read).
  - At most one address handshake per cycle. prio_read toggles on every accepted address.
- Accepted AR:
  - Latch id, addr, len, size, burst.
  - Go to RWAIT for RLAT-1 cycles, or directly to RDATA when RLAT=1. First rvalid appears exactly RLAT cycles after the handshake.
- RDATA:
  - rvalid held high. rdata/rresp/rlast stay stable until rready.
  - On each beat handshake, advance to the next beat the following cycle (one beat per cycle under continuous rready).
  - rlast is asserted on beat index == len. After the last handshake, return to IDLE. arready is not high in that same cycle.
- Accepted AW:
  - Latch fields and go to WDATA. wready is high in WDATA.
  - Each w handshake writes the bytes selected by wstrb at the current beat address.
  - Beats with index > awlen are accepted but discarded.
  - On wlast handshake go to WRESP: bvalid=1, bid=latched awid, held until bready, then IDLE.
- Beat address:
  - INCR: base + (beat << size).
  - FIXED: base.
  - WRAP: treated as INCR unless the optional feature is built in.
  - Word index = addr[ADDR_BITS+1:2]. No 4KB-boundary check.
- Errors (resp 2'b10 SLVERR, otherwise OKAY 2'b00):
  - size > 2: reads return rdata 0; writes perform no stores.
  - wlast arriving at a beat index != awlen: bresp=SLVERR, but stores already made are kept.
- Narrow transfers (size < 2): rdata returns the full word; the master selects lanes. Writes rely on wstrb only.
- Reset mid-burst: the transaction is abandoned immediately, memory contents are retained, outputs are 0 the next cycle.

Optional Feature:
- AXI_SLAVE_WRAP_EN defined:
  - arburst/awburst 2'b10 perform WRAP. Address wraps within an aligned window of (len+1)<<size bytes.
  - len must be 1, 3, 7 or 15; any other len returns SLVERR on all beats / bresp, with no stores.
- Undefined: WRAP is handled as INCR with OKAY response.

Decomposition:
- Add to the shared common package:
  - axi_burst_t enum: FIXED=2'b00, INCR=2'b01, WRAP=2'b10.
  - axi_resp_t: OKAY=2'b00, SLVERR=2'b10.
  - AXI_MAX_BEATS=16.
- Reuse the existing addr_t, word_t and strobe_t.
- One sub-module: sram_byteen, a synchronous-write, combinational-read 32-bit array with a 4-bit byte enable, parameterised by ADDR_BITS.

Test Plan:
- Single write then read:
  - AW addr 0x100, len 0, size 2, wdata 0xDEADBEEF, strb 0xF; then AR 0x100 len 0.
  - Expect bresp 0, bid echoed, rdata 0xDEADBEEF, rlast=1, rvalid exactly RLAT cycles after AR.
- INCR burst:
  - Write 4 beats at 0x200 with data 1..4, then read len 3 with rready toggled every other cycle.
  - Expect data 1,2,3,4 in order, stable while stalled, rlast only on beat 4.
- Byte strobes:
  - Write 0x11223344 at 0x300, then strb 0x2 with wdata 0x0000AA00.
  - Read back 0x1122AA44.
- Simultaneous arvalid and awvalid right after reset:
  - Read granted first (prio_read=1), write second; then the next contested pair grants the write first.
- Error cases:
  - arsize 3 -> rresp 2'b10, rdata 0.
  - awlen 3 with wlast on beat 2 -> bresp 2'b10, beats 0..1 stored.
- WRAP with AXI_SLAVE_WRAP_EN:
  - Read len 3, size 2 at 0x408 returns words 0x408, 0x40C, 0x400, 0x404.
  - Without the macro, the same read returns 0x408..0x414.
- Reset asserted during beat 2 of a read:
  - rvalid 0 the next cycle, and a new AR is accepted after reset releases.
